// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_pkg
//  Purpose  : Shared MIPS32 constants: opcodes, fetch reset values, fetch
//             FSM state encoding and fetch datapath select encodings.
//  Revision : 1.0  initial release
// ============================================================================
package mips32_pkg;

    // Primary opcode field instr[31:26], shared with the decoder
    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_REGIMM  = 6'h01;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_SLTI    = 6'h0A;
    localparam logic [5:0] c_OP_ANDI    = 6'h0C;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;

    // Fetch defaults: sll $0,$0,0 is the canonical NOP
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Next-PC source
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_TARGET   = 2'd2,
        PC_REDIRECT = 2'd3
    } pc_sel_t;

    // IF/ID register update source (FLUSH also serves as a bubble)
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_MEM   = 2'd1,
        IFID_SKID  = 2'd2,
        IFID_FLUSH = 2'd3
    } ifid_sel_t;

endpackage : mips32_pkg
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc
//  Purpose  : Program counter register, +4 incrementer and redirect-target
//             mux (jump has priority over taken branch).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc
    import mips32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_sel_t     i_pc_sel,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_ifid_pc_plus4,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_inc,
    output logic [31:0] o_target
);

    logic [31:0] r_pc;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    // Jump keeps the region bits of the registered pc_plus4; targets are
    // forced word aligned by masking rather than slicing.
    always_comb begin
        w_jump_target   = (i_ifid_pc_plus4 & 32'hF000_0000) | {4'b0000, i_jump_index, 2'b00};
        w_branch_target = i_branch_target & 32'hFFFF_FFFC;
        o_target        = i_jump ? w_jump_target : w_branch_target;
        o_pc_inc        = r_pc + 32'd4;   // wraps modulo 2^32
        o_pc            = r_pc;
    end

    // PC register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (i_pc_sel)
                PC_INC:      r_pc <= o_pc_inc;
                PC_TARGET:   r_pc <= o_target;
                PC_REDIRECT: r_pc <= i_redirect_pc;
                default:     r_pc <= r_pc;
            endcase
        end
    end

endmodule : fetch_pc
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : MIPS32 instruction fetch stage: request FSM with a one-entry
//             skid buffer for decode stalls, redirect draining of an
//             outstanding request, and the IF/ID pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch
    import mips32_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] instruct,
    output logic [31:0] pc_plus4,
    output logic        if_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    pc_sel_t      w_pc_sel;
    ifid_sel_t    w_ifid_sel;
    logic         w_skid_load;
    logic         w_rpc_load;
    logic         w_req;
    logic         w_redirect;

    logic [31:0]  w_pc;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_target;

    logic [31:0]  r_skid_instr;
    logic [31:0]  r_skid_pc4;
    logic [31:0]  r_redirect_pc;
    logic [31:0]  r_instruct;
    logic [31:0]  r_pc_plus4;
    logic         r_if_valid;

    assign w_redirect = jump | branch_taken;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk             (clk),
        .rst             (rst),
        .i_pc_sel        (w_pc_sel),
        .i_jump          (jump),
        .i_jump_index    (jump_index),
        .i_branch_target (branch_target),
        .i_ifid_pc_plus4 (r_pc_plus4),
        .i_redirect_pc   (r_redirect_pc),
        .o_pc            (w_pc),
        .o_pc_inc        (w_pc_inc),
        .o_target        (w_target)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and datapath controls; redirect always beats stall
    always_comb begin
        w_state_next = r_state;
        w_pc_sel     = PC_HOLD;
        w_ifid_sel   = IFID_HOLD;
        w_skid_load  = 1'b0;
        w_rpc_load   = 1'b0;
        w_req        = 1'b1;
        case (r_state)
            ST_FETCH: begin
                if (w_redirect) begin
                    w_ifid_sel = IFID_FLUSH;
                    if (imem_ready) begin
                        w_pc_sel = PC_TARGET;
                    end else begin
                        w_rpc_load   = 1'b1;
                        w_state_next = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    w_pc_sel = PC_INC;
                    if (stall) begin
                        w_skid_load  = 1'b1;
                        w_state_next = ST_HOLD;
                    end else begin
                        w_ifid_sel = IFID_MEM;
                    end
                end else if (!stall) begin
                    w_ifid_sel = IFID_FLUSH;   // bubble
                end
            end
            ST_HOLD: begin
                w_req = 1'b0;
                if (w_redirect) begin
                    w_pc_sel     = PC_TARGET;
                    w_ifid_sel   = IFID_FLUSH;
                    w_state_next = ST_FETCH;
                end else if (!stall) begin
                    w_ifid_sel   = IFID_SKID;
                    w_state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                w_ifid_sel = IFID_FLUSH;
                if (imem_ready) begin
                    // A redirect arriving on the completing cycle is the newest
                    w_pc_sel     = w_redirect ? PC_TARGET : PC_REDIRECT;
                    w_state_next = ST_FETCH;
                end else if (w_redirect) begin
                    w_rpc_load = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Skid buffer and pending redirect address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_instr  <= 32'h0;
            r_skid_pc4    <= 32'h0;
            r_redirect_pc <= 32'h0;
        end else begin
            if (w_skid_load) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc4   <= w_pc_inc;
            end
            if (w_rpc_load) begin
                r_redirect_pc <= w_target;
            end
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instruct <= NOP_INSTR;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_if_valid <= 1'b0;
        end else begin
            case (w_ifid_sel)
                IFID_MEM: begin
                    r_instruct <= imem_rdata;
                    r_pc_plus4 <= w_pc_inc;
                    r_if_valid <= 1'b1;
                end
                IFID_SKID: begin
                    r_instruct <= r_skid_instr;
                    r_pc_plus4 <= r_skid_pc4;
                    r_if_valid <= 1'b1;
                end
                IFID_FLUSH: begin
                    r_instruct <= NOP_INSTR;
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_instruct <= r_instruct;
                end
            endcase
        end
    end

    // Request is masked during reset so an abandoned fetch is never visible
    assign imem_req  = w_req & ~rst;
    assign imem_addr = w_pc;
    assign instruct  = r_instruct;
    assign pc_plus4  = r_pc_plus4;
    assign if_valid  = r_if_valid;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed self-checking bench for instr_fetch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic [31:0] instruct;
    logic [31:0] pc_plus4;
    logic        if_valid;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .instruct      (instruct),
        .pc_plus4      (pc_plus4),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
        checks++; if (instruct !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 00000000", instruct); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc4: got %h want 00000004", pc_plus4); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1; imem_rdata = 32'hAAAA_0001;
        step();
        checks++; if (instruct !== 32'hAAAA_0001) begin errors++; $display("FAIL seq_a_instr: got %h want aaaa0001", instruct); end
        checks++; if (pc_plus4 !== 32'h4 || if_valid !== 1'b1) begin errors++; $display("FAIL seq_a_pc4: got %h/%b want 00000004/1", pc_plus4, if_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_a_addr: got %h want 00000004", imem_addr); end
        imem_rdata = 32'hBBBB_0002;
        step();
        checks++; if (instruct !== 32'hBBBB_0002 || pc_plus4 !== 32'h8) begin errors++; $display("FAIL seq_b: got %h/%h want bbbb0002/00000008", instruct, pc_plus4); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_b_addr: got %h want 00000008", imem_addr); end
        imem_rdata = 32'hCCCC_0003;
        step();
        checks++; if (instruct !== 32'hCCCC_0003 || pc_plus4 !== 32'hC || if_valid !== 1'b1) begin errors++; $display("FAIL seq_c: got %h/%h/%b want cccc0003/0000000c/1", instruct, pc_plus4, if_valid); end
        imem_ready = 1'b0;
        step();
        checks++; if (instruct !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL bubble: got %h/%b want 00000000/0", instruct, if_valid); end
        checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL wait_addr: got %h/%b want 0000000c/1", imem_addr, imem_req); end
    endtask

    task automatic test_stall();
        rst = 1'b1; step(); rst = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'hAAAA_0001;
        step();
        checks++; if (instruct !== 32'hAAAA_0001 || imem_addr !== 32'h4) begin errors++; $display("FAIL stl_a: got %h/%h want aaaa0001/00000004", instruct, imem_addr); end
        imem_rdata = 32'hBBBB_0002; stall = 1'b1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stl_hold_req: got %b want 0", imem_req); end
        checks++; if (instruct !== 32'hAAAA_0001 || pc_plus4 !== 32'h4 || if_valid !== 1'b1) begin errors++; $display("FAIL stl_ifid: got %h/%h/%b want aaaa0001/00000004/1", instruct, pc_plus4, if_valid); end
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        step(); step();
        checks++; if (imem_req !== 1'b0 || instruct !== 32'hAAAA_0001) begin errors++; $display("FAIL stl_keep: got %b/%h want 0/aaaa0001", imem_req, instruct); end
        stall = 1'b0;
        step();
        checks++; if (instruct !== 32'hBBBB_0002 || pc_plus4 !== 32'h8 || if_valid !== 1'b1) begin errors++; $display("FAIL stl_release: got %h/%h/%b want bbbb0002/00000008/1", instruct, pc_plus4, if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stl_resume: got %b/%h want 1/00000008", imem_req, imem_addr); end
    endtask

    task automatic test_jump();
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_0001;
        branch_taken = 1'b1; branch_target = 32'h1000_0005;
        step();
        checks++; if (imem_addr !== 32'h1000_0004) begin errors++; $display("FAIL br_ready_addr: got %h want 10000004", imem_addr); end
        checks++; if (instruct !== 32'h0 || if_valid !== 1'b0 || pc_plus4 !== 32'h8) begin errors++; $display("FAIL br_flush: got %h/%b/%h want 00000000/0/00000008", instruct, if_valid, pc_plus4); end
        branch_taken = 1'b0; imem_rdata = 32'hDDDD_0004;
        step();
        checks++; if (instruct !== 32'hDDDD_0004 || pc_plus4 !== 32'h1000_0008) begin errors++; $display("FAIL jmp_pre: got %h/%h want dddd0004/10000008", instruct, pc_plus4); end
        jump = 1'b1; jump_index = 26'h000_0040;
        branch_taken = 1'b1; branch_target = 32'h300; stall = 1'b1; imem_rdata = 32'hDEAD_0002;
        step();
        checks++; if (imem_addr !== 32'h1000_0100 || imem_req !== 1'b1) begin errors++; $display("FAIL jmp_addr: got %h/%b want 10000100/1", imem_addr, imem_req); end
        checks++; if (instruct !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL jmp_flush: got %h/%b want 00000000/0", instruct, if_valid); end
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    endtask

    task automatic test_drain();
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h180;
        step();
        checks++; if (imem_addr !== 32'h1000_0100 || imem_req !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL drn_enter: got %h/%b/%b want 10000100/1/0", imem_addr, imem_req, if_valid); end
        branch_target = 32'h200;
        step();
        checks++; if (imem_addr !== 32'h1000_0100) begin errors++; $display("FAIL drn_stable: got %h want 10000100", imem_addr); end
        branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_0003;
        step();
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL drn_target: got %h want 00000200", imem_addr); end
        checks++; if (instruct !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL drn_discard: got %h/%b want 00000000/0", instruct, if_valid); end
        imem_rdata = 32'hEEEE_0005;
        step();
        checks++; if (instruct !== 32'hEEEE_0005 || pc_plus4 !== 32'h204 || imem_addr !== 32'h204) begin errors++; $display("FAIL drn_after: got %h/%h/%h want eeee0005/00000204/00000204", instruct, pc_plus4, imem_addr); end
        imem_ready = 1'b0;
    endtask

    task automatic test_reset_in_drain();
        branch_taken = 1'b1; branch_target = 32'h400;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h204 || imem_req !== 1'b1) begin errors++; $display("FAIL rd_enter: got %h/%b want 00000204/1", imem_addr, imem_req); end
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rd_async_req: got %b/%h want 0/00000000", imem_req, imem_addr); end
        checks++; if (instruct !== 32'h0 || pc_plus4 !== 32'h4 || if_valid !== 1'b0) begin errors++; $display("FAIL rd_async_ifid: got %h/%h/%b want 00000000/00000004/0", instruct, pc_plus4, if_valid); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rd_first: got %b/%h want 1/00000000", imem_req, imem_addr); end
        imem_ready = 1'b1; imem_rdata = 32'h6666_0007;
        step();
        checks++; if (instruct !== 32'h6666_0007 || pc_plus4 !== 32'h4 || imem_addr !== 32'h4) begin errors++; $display("FAIL rd_fetch: got %h/%h/%h want 66660007/00000004/00000004", instruct, pc_plus4, imem_addr); end
    endtask

    task automatic test_wrap();
        imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        step();
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
        branch_taken = 1'b0; imem_rdata = 32'h7777_0008;
        step();
        checks++; if (instruct !== 32'h7777_0008 || pc_plus4 !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc4: got %h/%h/%b want 77770008/00000000/1", instruct, pc_plus4, if_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 00000000", imem_addr); end
        imem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_drain();
        test_reset_in_drain();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0000, instruction word presented on flush or bubble.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: imem_req  out  1  instruction-memory request.
REQ-006 Port: imem_addr  out  32  word-aligned fetch address.
REQ-007 Port: imem_ready  in  1  imem_rdata valid this cycle; completes the request.
REQ-008 Port: imem_rdata  in  32  fetched instruction word.
REQ-009 Port: stall  in  1  decode cannot accept a new instruction.
REQ-010 Port: branch_taken, branch_target  in  1, 32  taken-branch redirect and its target.
REQ-011 Port: jump, jump_index  in  1, 26  J redirect and its instr[25:0] field.
REQ-012 Port: instruct  out  32  IF/ID instruction register, feeds the decoder.
REQ-013 Port: pc_plus4  out  32  IF/ID register: address of instruct + 4.
REQ-014 Port: if_valid  out  1  instruct holds a real fetched instruction.

Function
REQ-015 States: FETCH, HOLD, DRAIN; exactly one active.
REQ-016 Redirect = jump | branch_taken; when both are asserted, jump wins.
REQ-017 Jump target = {pc_plus4[31:28], jump_index, 2'b00}, using the registered pc_plus4; branch target = {branch_target[31:2], 2'b00}.
REQ-018 Outputs in FETCH: imem_req=1, imem_addr=pc. In DRAIN: imem_req=1, imem_addr=the held pc. In HOLD: imem_req=0.
REQ-019 imem_addr stays stable while imem_req=1 and imem_ready=0.
REQ-020 FETCH, imem_ready=1, no redirect, stall=0: instruct<=imem_rdata, pc_plus4<=pc+4, if_valid<=1, pc<=pc+4. Latency is one cycle from imem_ready to instruct.
REQ-021 FETCH, imem_ready=1, no redirect, stall=1: capture imem_rdata and pc+4 into the skid buffer, pc<=pc+4, go HOLD; IF/ID is unchanged.
REQ-022 FETCH, imem_ready=0, no redirect: if stall=0, instruct<=NOP_INSTR and if_valid<=0 (bubble); if stall=1, IF/ID is unchanged.
REQ-023 HOLD, stall=0, no redirect: IF/ID<=skid buffer, if_valid<=1, go FETCH. HOLD with stall=1 holds everything.
REQ-024 Redirect in FETCH with imem_ready=1: discard the data, pc<=target, flush IF/ID (NOP_INSTR, if_valid=0), stay in FETCH.
REQ-025 Redirect in FETCH with imem_ready=0: redirect_pc<=target, flush IF/ID, go DRAIN.
REQ-026 Redirect in HOLD: discard the skid buffer, pc<=target, flush IF/ID, go FETCH.
REQ-027 DRAIN: if_valid=0. A new redirect overwrites redirect_pc. On imem_ready, discard the data, pc<=redirect_pc, go FETCH.
REQ-028 Redirect overrides stall in every state.
REQ-029 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

Reset
REQ-030 While rst=1: pc=RESET_PC, state=FETCH, imem_req=0, instruct=NOP_INSTR, pc_plus4=RESET_PC+4, if_valid=0, skid buffer and redirect_pc cleared.
REQ-031 Reset mid-request abandons the outstanding fetch; the first fetch after deassertion is RESET_PC.

Structure
REQ-032 Package mips32_pkg holds: opcode constants, NOP_INSTR, RESET_PC, and the fetch-state enum; the decoder shares the opcode constants.
REQ-033 One sub-module, fetch_pc, holds the PC register, the +4 adder, and the redirect-target mux; the FSM, skid buffer, and IF/ID register stay in instr_fetch.

Verification
REQ-034 Release reset, imem_ready=1 each cycle, words A,B,C -> imem_addr 0,4,8; instruct A,B,C one cycle later; pc_plus4 4,8,12; if_valid=1.
REQ-035 stall=1 for 3 cycles while word B returns -> IF/ID holds A, state HOLD, imem_req=0; when stall drops, instruct=B and fetch resumes at 8.
REQ-036 jump=1, jump_index=26'h0000040, pc_plus4=32'h1000_0008 -> next imem_addr=32'h1000_0100; instruct=NOP_INSTR, if_valid=0.
REQ-037 branch_taken=1, target 32'h200, while imem_ready=0 -> DRAIN; returned word is discarded; next imem_addr=32'h200.
REQ-038 Assert rst during a DRAIN wait -> all outputs at reset values immediately (async); first fetch after release is RESET_PC.
REQ-039 Fetch at 32'hFFFF_FFFC -> pc_plus4=0; next fetch address is 0.
